// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and sizing helpers for the pipelined ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_SUM = 3'd0,
    OP_AND = 3'd1,
    OP_OR  = 3'd2,
    OP_XOR = 3'd3,
    OP_SR  = 3'd4,
    OP_BCD = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

  // Width of a counter indexing the WIDTH/4 nibbles of an operand.
  function automatic int unsigned nib_cnt_w(input int unsigned width);
    int unsigned n;
    n = width / 4;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One decimal digit step: 4-bit digits plus carry, corrected by +6 when above 9.
module bcd_digit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] s;
  logic [3:0] adj;

  always_comb begin
    s     = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    adj   = s[3:0] + 4'd6;
    cout  = (s > 5'd9);
    digit = cout ? adj : s[3:0];
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: accept in IDLE, compute in EXEC (one cycle, or one per nibble
// for BCD), then hold registered result and flags in DONE until taken.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             of,
  output logic             cout,
  output logic             hcout,
  output logic             zf,
  output logic             nf,
  output logic             err
);

  localparam int unsigned    NIBS     = WIDTH / 4;
  localparam int unsigned    CW       = nib_cnt_w(WIDTH);
  localparam logic [CW-1:0]  NIB_LAST = CW'(NIBS - 1);

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r, acc;
  logic [2:0]       op_r;
  logic             cin_r, carry_r, hc_bcd;
  logic [CW-1:0]    nib_cnt;

  logic [3:0]       digit;
  logic             dcout;
  logic [WIDTH:0]   sum_full;
  logic [4:0]       sum_lo;
  logic [WIDTH-1:0] res_n;
  logic             of_n, cout_n, hc_n, err_n;

  // Operands shift right during BCD so the adder always sees the low nibble.
  bcd_digit_adder u_bcd (
    .a     (a_r[3:0]),
    .b     (b_r[3:0]),
    .cin   (carry_r),
    .digit (digit),
    .cout  (dcout)
  );

  always_comb begin
    sum_full = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, cin_r};
    sum_lo   = {1'b0, a_r[3:0]} + {1'b0, b_r[3:0]} + {4'b0, cin_r};
    res_n    = '0;
    of_n     = 1'b0;
    cout_n   = 1'b0;
    hc_n     = 1'b0;
    err_n    = 1'b0;
    case (op_r)
      OP_SUM: begin
        res_n  = sum_full[WIDTH-1:0];
        cout_n = sum_full[WIDTH];
        hc_n   = sum_lo[4];
        of_n   = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_full[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_AND: res_n = a_r & b_r;
      OP_OR:  res_n = a_r | b_r;
      OP_XOR: res_n = a_r ^ b_r;
      OP_SR: begin
        res_n  = {cin_r, a_r[WIDTH-1:1]};
        cout_n = a_r[0];
      end
      OP_BCD: begin
        // Evaluated on the last nibble: lower digits already sit in acc.
        res_n              = acc;
        res_n[WIDTH-1 -: 4] = digit;
        cout_n             = dcout;
        hc_n               = hc_bcd;
      end
      default: begin
        res_n = a_r;
        err_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      of        <= 1'b0;
      cout      <= 1'b0;
      hcout     <= 1'b0;
      zf        <= 1'b0;
      nf        <= 1'b0;
      err       <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      op_r      <= '0;
      cin_r     <= 1'b0;
      carry_r   <= 1'b0;
      hc_bcd    <= 1'b0;
      nib_cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= a;
            b_r      <= b;
            op_r     <= op;
            cin_r    <= cin;
            carry_r  <= cin;
            hc_bcd   <= 1'b0;
            acc      <= '0;
            nib_cnt  <= '0;
            in_ready <= 1'b0;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op_r == OP_BCD && nib_cnt != NIB_LAST) begin
            for (int unsigned i = 0; i < NIBS; i++) begin
              if (nib_cnt == CW'(i)) acc[i*4 +: 4] <= digit;
            end
            a_r     <= a_r >> 4;
            b_r     <= b_r >> 4;
            carry_r <= dcout;
            if (nib_cnt == '0) hc_bcd <= dcout;
            nib_cnt <= nib_cnt + CW'(1);
          end else begin
            result    <= res_n;
            of        <= of_n;
            cout      <= cout_n;
            hcout     <= hc_n;
            err       <= err_n;
            zf        <= (res_n == '0);
            nf        <= res_n[WIDTH-1];
            nib_cnt   <= '0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: fixed vector table, random ops against an arithmetic
// model, and hand-written backpressure / reset / 16-bit BCD sequences.
module tb_alu_pipe;

  typedef struct {
    logic [15:0] res;
    logic [5:0]  fl;   // {of, cout, hcout, zf, nf, err}
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       cin;
    logic [7:0] res;
    logic [5:0] fl;
    int         lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic       in_valid8 = 1'b0, out_ready8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [2:0] op8 = '0;
  logic       in_ready8, out_valid8, of8, cout8, hcout8, zf8, nf8, err8;
  logic [7:0] result8;
  logic [5:0] flags8;

  logic        in_valid16 = 1'b0, out_ready16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [2:0]  op16 = '0;
  logic        in_ready16, out_valid16, of16, cout16, hcout16, zf16, nf16, err16;
  logic [15:0] result16;
  logic [5:0]  flags16;

  assign flags8  = {of8, cout8, hcout8, zf8, nf8, err8};
  assign flags16 = {of16, cout16, hcout16, zf16, nf16, err16};

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .cin(cin8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .of(of8), .cout(cout8),
    .hcout(hcout8), .zf(zf8), .nf(nf8), .err(err8)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .cin(cin16), .out_valid(out_valid16),
    .out_ready(out_ready16), .result(result16), .of(of16), .cout(cout16),
    .hcout(hcout16), .zf(zf16), .nf(nf16), .err(err16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference computed from the op definitions with plain integer arithmetic.
  function automatic exp_t model(input int unsigned w, input int unsigned av,
                                 input int unsigned bv, input int unsigned opv,
                                 input int unsigned cv);
    exp_t        m;
    int unsigned r, s, c, d, an, bn, mask;
    logic        ofv, co, hc, er;
    r = 0; ofv = 0; co = 0; hc = 0; er = 0;
    mask = (32'd1 << w) - 1;
    case (opv)
      0: begin
        s   = av + bv + cv;
        r   = s & mask;
        co  = 1'((s >> w) & 1);
        hc  = ((av & 15) + (bv & 15) + cv) > 15;
        ofv = (((av >> (w-1)) & 1) == ((bv >> (w-1)) & 1)) &&
              (((r >> (w-1)) & 1) != ((av >> (w-1)) & 1));
      end
      1: r = av & bv;
      2: r = av | bv;
      3: r = av ^ bv;
      4: begin
        r  = (cv << (w-1)) | (av >> 1);
        co = 1'(av & 1);
      end
      5: begin
        c = cv;
        for (int unsigned n = 0; n < w / 4; n++) begin
          an = (av >> (4*n)) & 15;
          bn = (bv >> (4*n)) & 15;
          s  = an + bn + c;
          if (s > 9) begin d = (s + 6) % 16; c = 1; end
          else       begin d = s;            c = 0; end
          r = r | (d << (4*n));
          if (n == 0) hc = 1'(c);
        end
        co = 1'(c);
      end
      default: begin
        r  = av;
        er = 1'b1;
      end
    endcase
    m.res = 16'(r);
    m.fl  = {ofv, co, hc, (r == 0), 1'((r >> (w-1)) & 1), er};
    return m;
  endfunction

  task automatic do_op8(input string nm, input logic [7:0] av, input logic [7:0] bv,
                        input logic [2:0] opv, input logic cv, input logic [7:0] er,
                        input logic [5:0] ef, input int el);
    int lat;
    @(negedge clk);
    chk({nm, " in_ready"}, in_ready8, 1);
    a8 = av; b8 = bv; op8 = opv; cin8 = cv; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom); cin8 = 1'($urandom);
    lat = 1;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, el);
    chk({nm, " result"}, result8, er);
    chk({nm, " flags"}, flags8, ef);
    @(negedge clk); out_ready8 = 1'b1;
    @(posedge clk); #1; out_ready8 = 1'b0;
    chk({nm, " drained"}, out_valid8, 0);
  endtask

  task automatic do_op16(input string nm, input logic [15:0] av, input logic [15:0] bv,
                         input logic [2:0] opv, input logic cv, input logic [15:0] er,
                         input logic [5:0] ef, input int el);
    int lat;
    @(negedge clk);
    a16 = av; b16 = bv; op16 = opv; cin16 = cv; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 1;
    while (!out_valid16 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, el);
    chk({nm, " result"}, result16, er);
    chk({nm, " flags"}, flags16, ef);
    @(negedge clk); out_ready16 = 1'b1;
    @(posedge clk); #1; out_ready16 = 1'b0;
  endtask

  vec_t tbl[12];

  initial begin
    exp_t       m;
    logic [7:0] av, bv;
    logic [2:0] opv;
    logic       cv;
    int         lat;

    tbl[0]  = '{8'h50, 8'h50, 3'd0, 1'b0, 8'hA0, 6'b100010, 2};
    tbl[1]  = '{8'h58, 8'h46, 3'd5, 1'b1, 8'h05, 6'b011000, 3};
    tbl[2]  = '{8'h81, 8'h00, 3'd4, 1'b1, 8'hC0, 6'b010010, 2};
    tbl[3]  = '{8'h01, 8'h00, 3'd4, 1'b0, 8'h00, 6'b010100, 2};
    tbl[4]  = '{8'h3C, 8'h55, 3'd7, 1'b1, 8'h3C, 6'b000001, 2};
    tbl[5]  = '{8'hFF, 8'h01, 3'd0, 1'b0, 8'h00, 6'b011100, 2};
    tbl[6]  = '{8'hF0, 8'h3C, 3'd1, 1'b1, 8'h30, 6'b000000, 2};
    tbl[7]  = '{8'h0F, 8'h30, 3'd2, 1'b0, 8'h3F, 6'b000000, 2};
    tbl[8]  = '{8'hAA, 8'hAA, 3'd3, 1'b1, 8'h00, 6'b000100, 2};
    tbl[9]  = '{8'h80, 8'h12, 3'd6, 1'b0, 8'h80, 6'b000011, 2};
    tbl[10] = '{8'h99, 8'h01, 3'd5, 1'b0, 8'h00, 6'b011100, 3};
    tbl[11] = '{8'h7F, 8'h00, 3'd0, 1'b1, 8'h80, 6'b101010, 2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", out_valid8, 0);
    chk("rst result", result8, 0);
    chk("rst flags", flags8, 0);
    chk("rst in_ready", in_ready8, 1);
    chk("rst16 result", result16, 0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i])
      do_op8($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].cin,
             tbl[i].res, tbl[i].fl, tbl[i].lat);

    for (int i = 0; i < 40; i++) begin
      av = 8'($urandom); bv = 8'($urandom);
      opv = 3'($urandom_range(0, 7)); cv = 1'($urandom);
      m = model(8, av, bv, opv, cv);
      do_op8($sformatf("rand%0d op%0d", i, opv), av, bv, opv, cv, m.res[7:0], m.fl,
             (opv == 3'd5) ? 3 : 2);
    end

    // Backpressure: result held, no accept while DONE, ready returns after take
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; op8 = 3'd0; cin8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1; in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'd3;
      @(posedge clk); #1;
      chk($sformatf("bp%0d result", i), result8, 8'h47);
      chk($sformatf("bp%0d flags", i), flags8, 6'b000000);
      chk($sformatf("bp%0d in_ready", i), in_ready8, 0);
      chk($sformatf("bp%0d out_valid", i), out_valid8, 1);
    end
    @(negedge clk); out_ready8 = 1'b1;
    @(posedge clk); #1;
    chk("bp release in_ready", in_ready8, 1);
    chk("bp release out_valid", out_valid8, 0);
    @(negedge clk); in_valid8 = 1'b0; out_ready8 = 1'b0;
    @(posedge clk); #1;
    chk("bp no same-cycle accept", in_ready8, 1);

    // Reset during the second BCD nibble
    @(negedge clk);
    a8 = 8'h58; b8 = 8'h46; op8 = 3'd5; cin8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1; in_valid8 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid8, 0);
    chk("midrst result", result8, 0);
    chk("midrst flags", flags8, 0);
    chk("midrst in_ready", in_ready8, 1);
    @(negedge clk); in_valid8 = 1'b1; op8 = 3'd0;
    @(posedge clk); #1;
    chk("rst no accept", in_ready8, 1);
    @(negedge clk); in_valid8 = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst idle", out_valid8, 0);
    do_op8("post rst sum", 8'hFF, 8'h01, 3'd0, 1'b0, 8'h00, 6'b011100, 2);

    // 16-bit instance
    do_op16("w16 bcd", 16'h9999, 16'h0001, 3'd5, 1'b0, 16'h0000, 6'b011100, 5);
    for (int i = 0; i < 6; i++) begin
      av = 8'($urandom); bv = 8'($urandom);
      opv = 3'($urandom_range(0, 7)); cv = 1'($urandom);
      m = model(16, {av, bv}, {bv, av}, opv, cv);
      do_op16($sformatf("w16 rand%0d op%0d", i, opv), {av, bv}, {bv, av}, opv, cv,
              m.res, m.fl, (opv == 3'd5) ? 5 : 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
